fft_bf_stage: RTL and testbench

FFT_BF_STAGE -- requirements
Module: fft_bf_stage

---
 rtl/fft_pkg.sv | 7 +
 rtl/fft_bfly_core.sv | 21 ++
 rtl/fft_bf_stage.sv | 107 ++++++++++
 tb/tb_fft_bf_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding and default parameters for the radix-2 butterfly stage.
package fft_pkg;
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_N_PTS  = 8;
  localparam int DEF_SPAN   = 4;
endpackage

// File: rtl/fft_bfly_core.sv
// fft_bfly_core: one real butterfly lane (sum/difference at DATA_W+1 bits, then reduced).
// FFT_BF_SCALE_EN selects halving (arithmetic shift) instead of wrap-around truncation.
module fft_bfly_core #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] s,
  output logic signed [DATA_W-1:0] d
);
  logic signed [DATA_W:0] sum, dif;
  assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign dif = {a[DATA_W-1], a} - {b[DATA_W-1], b};
`ifdef FFT_BF_SCALE_EN
  assign s = DATA_W'(sum >>> 1);
  assign d = DATA_W'(dif >>> 1);
`else
  assign s = DATA_W'(sum);
  assign d = DATA_W'(dif);
`endif
endmodule

// File: rtl/fft_bf_stage.sv
// fft_bf_stage: frame-buffered in-place butterfly stage (LOAD -> COMPUTE -> DRAIN).
// Optional FFT_BF_SCALE_EN halves every butterfly result to avoid overflow.
module fft_bf_stage
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_PTS  = DEF_N_PTS,
  parameter int SPAN   = DEF_SPAN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last,
  output logic              frame_err
);
  localparam int IW = $clog2(N_PTS);
  localparam logic [IW-1:0] LAST      = IW'(N_PTS - 1);
  localparam logic [IW-1:0] HALF_LAST = IW'(N_PTS / 2 - 1);

  if (DATA_W < 2) begin : g_bad_w
    $error("DATA_W must be >= 2");
  end
  if (N_PTS < 2 || (N_PTS & (N_PTS - 1)) != 0) begin : g_bad_n
    $error("N_PTS must be a power of two >= 2");
  end
  if (SPAN < 1 || (SPAN & (SPAN - 1)) != 0 || SPAN > N_PTS / 2) begin : g_bad_span
    $error("SPAN must be a power of two <= N_PTS/2");
  end

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, bi, bj;
  logic err_q, err_d;
  logic signed [DATA_W-1:0] mem_re_q [N_PTS];
  logic signed [DATA_W-1:0] mem_im_q [N_PTS];
  logic signed [DATA_W-1:0] mem_re_d [N_PTS];
  logic signed [DATA_W-1:0] mem_im_d [N_PTS];
  logic signed [DATA_W-1:0] s_re, d_re, s_im, d_im;

  // Butterfly b pairs i with i+SPAN, skipping the upper half of each 2*SPAN group.
  assign bi = IW'((int'(idx_q) / SPAN) * 2 * SPAN + int'(idx_q) % SPAN);
  assign bj = bi + IW'(SPAN);

  fft_bfly_core #(.DATA_W(DATA_W)) u_re (.a(mem_re_q[bi]), .b(mem_re_q[bj]), .s(s_re), .d(d_re));
  fft_bfly_core #(.DATA_W(DATA_W)) u_im (.a(mem_im_q[bi]), .b(mem_im_q[bj]), .s(s_im), .d(d_im));

  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == DRAIN;
  assign out_re    = out_valid ? mem_re_q[idx_q] : '0;
  assign out_im    = out_valid ? mem_im_q[idx_q] : '0;
  assign out_last  = out_valid && idx_q == LAST;
  assign frame_err = err_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
    mem_re_d = mem_re_q;
    mem_im_d = mem_im_q;
    unique case (state_q)
      LOAD: if (in_valid) begin
        mem_re_d[idx_q] = in_re;
        mem_im_d[idx_q] = in_im;
        err_d   = in_last != (idx_q == LAST);
        state_d = (in_last && idx_q == LAST) ? COMPUTE : LOAD;
        idx_d   = (err_d || in_last) ? '0 : idx_q + 1'b1;
      end
      COMPUTE: begin
        mem_re_d[bi] = s_re;
        mem_re_d[bj] = d_re;
        mem_im_d[bi] = s_im;
        mem_im_d[bj] = d_im;
        state_d = idx_q == HALF_LAST ? DRAIN : COMPUTE;
        idx_d   = idx_q == HALF_LAST ? '0 : idx_q + 1'b1;
      end
      DRAIN: if (out_ready) begin
        state_d = idx_q == LAST ? LOAD : DRAIN;
        idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_re_q <= mem_re_d;
    mem_im_q <= mem_im_d;
  end
endmodule

// File: tb/tb_fft_bf_stage.sv
// tb_fft_bf_stage: directed checks of fft_bf_stage (SPAN=4 and SPAN=1 instances share inputs).
// Expected values follow FFT_BF_SCALE_EN when it is defined for the build.
module tb_fft_bf_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [15:0] in_re = '0, in_im = '0;
  logic in_ready, out_valid, out_last, frame_err;
  logic [15:0] out_re, out_im;
  logic in_ready1, o1_valid, o1_last, err1;
  logic [15:0] o1_re, o1_im;
  int n_tests = 0, n_fail = 0;

`ifdef FFT_BF_SCALE_EN
  localparam logic [15:0] EXP_A  [8] = '{16'd3, 16'd4, 16'd5, 16'd6, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
  localparam logic [15:0] EXP_S1 [8] = '{16'd1, 16'hFFFF, 16'd3, 16'hFFFF, 16'd5, 16'hFFFF, 16'd7, 16'hFFFF};
  localparam logic [15:0] EXP_OV0 = 16'h4000;
  localparam logic [15:0] EXP_OV4 = 16'h3FFF;
`else
  localparam logic [15:0] EXP_A  [8] = '{16'd6, 16'd8, 16'd10, 16'd12, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC};
  localparam logic [15:0] EXP_S1 [8] = '{16'd3, 16'hFFFF, 16'd7, 16'hFFFF, 16'd11, 16'hFFFF, 16'd15, 16'hFFFF};
  localparam logic [15:0] EXP_OV0 = 16'h8000;
  localparam logic [15:0] EXP_OV4 = 16'h7FFE;
`endif

  logic [15:0] fr [8];
  logic [15:0] exp_re [8];
  logic [15:0] got_re [8], got_im [8], got1_re [8], got1_im [8];
  logic got_last [8], got1_last [8];

  fft_bf_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .frame_err(frame_err)
  );

  fft_bf_stage #(.SPAN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_valid(o1_valid), .out_ready(out_ready), .out_re(o1_re), .out_im(o1_im),
    .out_last(o1_last), .frame_err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] re, input logic last);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_re = re;
    in_im = '0;
    in_last = last;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_frame();
    for (int k = 0; k < 8; k++) push(fr[k], k == 7);
  endtask

  task automatic collect(input int stall_at);
    int t;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      chk("dut1_valid", {31'd0, o1_valid}, 32'd1);
      got_re[k] = out_re;
      got_im[k] = out_im;
      got_last[k] = out_last;
      got1_re[k] = o1_re;
      got1_im[k] = o1_im;
      got1_last[k] = o1_last;
      if (k == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_re", {16'd0, out_re}, {16'd0, exp_re[k]});
          chk("stall_im", {16'd0, out_im}, 32'd0);
          chk("stall_last", {31'd0, out_last}, 32'd0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_results(input string name, input logic with_span1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_re[%0d]", name, k), {16'd0, got_re[k]}, {16'd0, exp_re[k]});
      chk($sformatf("%s_im[%0d]", name, k), {16'd0, got_im[k]}, 32'd0);
      chk($sformatf("%s_last[%0d]", name, k), {31'd0, got_last[k]}, {31'd0, k == 7});
      if (with_span1) begin
        chk($sformatf("%s_s1re[%0d]", name, k), {16'd0, got1_re[k]}, {16'd0, EXP_S1[k]});
        chk($sformatf("%s_s1im[%0d]", name, k), {16'd0, got1_im[k]}, 32'd0);
        chk($sformatf("%s_s1last[%0d]", name, k), {31'd0, got1_last[k]}, {31'd0, k == 7});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) fr[k] = 16'(k + 1);
    exp_re = EXP_A;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_out_re", {16'd0, out_re}, 32'd0);
    chk("rst_out_im", {16'd0, out_im}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    send_frame();
    #1;
    chk("compute_in_ready", {31'd0, in_ready}, 32'd0);
    collect(2);
    check_results("ramp", 1'b1);

    for (int k = 0; k < 8; k++) fr[k] = '0;
    fr[0] = 16'h7FFF;
    fr[4] = 16'h0001;
    send_frame();
    collect(-1);
    chk("ovf_out0", {16'd0, got_re[0]}, {16'd0, EXP_OV0});
    chk("ovf_out4", {16'd0, got_re[4]}, {16'd0, EXP_OV4});

    for (int k = 0; k < 8; k++) fr[k] = 16'(k + 1);
    for (int k = 0; k < 6; k++) push(fr[k], k == 5);
    chk("err_pulse", {31'd0, frame_err}, 32'd1);
    chk("err_pulse_s1", {31'd0, err1}, 32'd1);
    chk("err_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("err_clear", {31'd0, frame_err}, 32'd0);
    send_frame();
    collect(-1);
    check_results("after_err", 1'b1);

    send_frame();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_re", {16'd0, out_re}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rel_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_rel_ready1", {31'd0, in_ready1}, 32'd1);
    send_frame();
    collect(-1);
    check_results("after_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
